// File: rtl/wfq_pkg.sv
// Shared definitions for the WFQ read-side service monitor: default sizes,
// FSM state encoding and a saturating increment helper.
package wfq_pkg;

    localparam int NUM_FLOWS_DEF = 4;
    localparam int FLOW_ID_W_DEF = 2;
    localparam int DATA_W_DEF    = 64;

    // Width the saturating helper operates at; counters up to 64 bits fit.
    localparam int SAT_W = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                 input logic [SAT_W-1:0] max_value);
        return (value >= max_value) ? value : value + SAT_W'(1);
    endfunction

endpackage

// File: rtl/wfq_req_delay.sv
// DEPTH-deep shift register of a request pulse; the last tap marks the cycle
// the matching read data is valid. Shifts every cycle, no enable.
module wfq_req_delay
    import wfq_pkg::*;
#(
    parameter int DEPTH = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic in_req,
    output logic out_strobe
);

    logic [DEPTH-1:0] shift_q;
    logic [DEPTH-1:0] shift_d;

    // NOTE: every variable written here gets a value first, so no latch is inferred.
    always_comb begin
        shift_d    = shift_q;
        shift_d[0] = in_req;
        for (int i = 1; i < DEPTH; i++) begin
            shift_d[i] = shift_q[i-1];
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign out_strobe = shift_q[DEPTH-1];

endmodule

// File: rtl/wfq_service_monitor.sv
// Per-flow served-word accountant on the scheduler read port: aligns requests
// with returned data, counts by flow tag (cumulative or windowed), registered readout.
module wfq_service_monitor
    import wfq_pkg::*;
#(
    parameter int NUM_FLOWS  = NUM_FLOWS_DEF,
    parameter int FLOW_ID_W  = FLOW_ID_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LATENCY = 7,
    parameter int CNT_W      = 32,
    parameter int WIN_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_enable,
    input  logic                 in_window_mode,
    input  logic [WIN_W-1:0]     in_window_len,
    input  logic                 in_clear,
    input  logic                 in_rd_packet_req,
    input  logic [DATA_W-1:0]    in_rd_data,
    input  logic [FLOW_ID_W-1:0] in_sel,
    output logic [CNT_W-1:0]     out_cnt,
    output logic [CNT_W+2:0]     out_bytes,
    output logic [CNT_W+5:0]     out_total,
    output logic [CNT_W-1:0]     out_unknown_cnt,
    output logic                 out_window_done
);

    localparam int BYTES_W        = CNT_W + 3;
    localparam int TOT_W          = CNT_W + 6;
    localparam int BYTES_PER_WORD = DATA_W / 8;
    localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_W{1'b1}});

    state_e               state_q, state_d;
    logic [WIN_W-1:0]     win_q, win_d;
    logic [CNT_W-1:0]     live_q [NUM_FLOWS];
    logic [CNT_W-1:0]     live_d [NUM_FLOWS];
    logic [CNT_W-1:0]     snap_q [NUM_FLOWS];
    logic [CNT_W-1:0]     snap_d [NUM_FLOWS];
    logic [CNT_W-1:0]     live_inc [NUM_FLOWS];
    logic [CNT_W-1:0]     unk_q, unk_d, unk_inc;
    logic [CNT_W-1:0]     unk_snap_q, unk_snap_d;
    logic                 done_q, done_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BYTES_W-1:0]   bytes_q, bytes_d;
    logic [TOT_W-1:0]     total_q, total_d;
    logic [CNT_W-1:0]     unk_out_q, unk_out_d;

    logic                 strobe;
    logic                 run;
    logic                 sample;
    logic                 boundary;
    logic [FLOW_ID_W-1:0] tag;
    logic [WIN_W-1:0]     win_last;
    logic                 unused_data;

    wfq_req_delay #(
        .DEPTH(RD_LATENCY)
    ) u_req_delay (
        .clk       (clk),
        .rst       (rst),
        .in_req    (in_rd_packet_req),
        .out_strobe(strobe)
    );

    assign tag         = in_rd_data[FLOW_ID_W-1:0];
    assign unused_data = ^in_rd_data[DATA_W-1:FLOW_ID_W];
    assign run         = (state_q == ST_RUN);
    assign sample      = strobe && run;
    // A zero window length behaves as a one-cycle window.
    assign win_last    = (in_window_len == '0) ? '0 : in_window_len - WIN_W'(1);
    assign boundary    = run && in_window_mode && !in_clear && (win_q >= win_last);
    assign done_d      = boundary;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_enable)  state_d = ST_RUN;
            ST_RUN:  if (!in_enable) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Held at 0 outside RUN so each entry to RUN starts a fresh window.
        win_d = win_q;
        if (!run || in_clear || boundary) begin
            win_d = '0;
        end else if (in_window_mode) begin
            win_d = win_q + WIN_W'(1);
        end
    end

    always_comb begin
        unk_inc = unk_q;
        if (sample && (int'(tag) >= NUM_FLOWS)) begin
            unk_inc = CNT_W'(sat_inc(SAT_W'(unk_q), CNT_MAX));
        end
        for (int i = 0; i < NUM_FLOWS; i++) begin
            live_inc[i] = live_q[i];
            if (sample && (tag == FLOW_ID_W'(i))) begin
                live_inc[i] = CNT_W'(sat_inc(SAT_W'(live_q[i]), CNT_MAX));
            end
        end

        // Clear wins over both the sample and the window boundary.
        unk_d      = unk_inc;
        unk_snap_d = unk_snap_q;
        for (int i = 0; i < NUM_FLOWS; i++) begin
            live_d[i] = live_inc[i];
            snap_d[i] = snap_q[i];
        end
        if (in_clear) begin
            unk_d = '0;
            for (int i = 0; i < NUM_FLOWS; i++) live_d[i] = '0;
        end else if (boundary) begin
            unk_snap_d = unk_inc;
            unk_d      = '0;
            for (int i = 0; i < NUM_FLOWS; i++) begin
                snap_d[i] = live_inc[i];
                live_d[i] = '0;
            end
        end
    end

    always_comb begin
        logic [CNT_W-1:0] src;
        src     = '0;
        cnt_d   = '0;
        total_d = '0;
        for (int i = 0; i < NUM_FLOWS; i++) begin
            src     = in_window_mode ? snap_q[i] : live_q[i];
            total_d = total_d + TOT_W'(src);
            if (in_sel == FLOW_ID_W'(i)) cnt_d = src;
        end
        bytes_d   = BYTES_W'(cnt_d) * BYTES_W'(BYTES_PER_WORD);
        unk_out_d = in_window_mode ? unk_snap_q : unk_q;
    end

    // NOTE: the counter arrays are flops, not RAM, so they take the async reset like any other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            win_q      <= '0;
            unk_q      <= '0;
            unk_snap_q <= '0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            bytes_q    <= '0;
            total_q    <= '0;
            unk_out_q  <= '0;
            for (int i = 0; i < NUM_FLOWS; i++) begin
                live_q[i] <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            unk_q      <= unk_d;
            unk_snap_q <= unk_snap_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            bytes_q    <= bytes_d;
            total_q    <= total_d;
            unk_out_q  <= unk_out_d;
            for (int i = 0; i < NUM_FLOWS; i++) begin
                live_q[i] <= live_d[i];
                snap_q[i] <= snap_d[i];
            end
        end
    end

    assign out_cnt         = cnt_q;
    assign out_bytes       = bytes_q;
    assign out_total       = total_q;
    assign out_unknown_cnt = unk_out_q;
    assign out_window_done = done_q;

endmodule
